// File: rtl/ab_loader_pkg.sv
// Shared definitions for the A/B operand-pair loader: FSM encoding and defaults.
package ab_loader_pkg;

    localparam int unsigned WIDTH_DEFAULT   = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned COUNT_W         = 8;

    typedef enum logic [1:0] {
        WAIT_A   = 2'd0,
        WAIT_B   = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } state_e;

    // The loader only takes bytes while it is filling one of the two operands.
    function automatic logic accepts_byte(input state_e s);
        return (s == WAIT_A) || (s == WAIT_B);
    endfunction

endpackage

// File: rtl/ab_loader_if.sv
// Byte-stream, register-pair write and status signals of the operand-pair loader.
interface ab_loader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] outA;
    logic [WIDTH-1:0] outB;
    logic             enA;
    logic             enB;
    logic             ack_in;
    logic             pair_done;
    logic [7:0]       pair_count;
    logic             err;
    logic             err_clr;

    // Loader side.
    modport slave (
        input  data_in, valid_in, ack_in, err_clr,
        output ready_in, outA, outB, enA, enB, pair_done, pair_count, err
    );

    // Byte source / register pair / status consumer side.
    modport master (
        output data_in, valid_in, ack_in, err_clr,
        input  ready_in, outA, outB, enA, enB, pair_done, pair_count, err
    );
endinterface

// File: rtl/ab_loader.sv
// Operand-pair loader: writes alternate stream bytes to operand A then B, waits for
// the register pair's both-loaded flag, and counts completed pairs or flags a timeout.
module ab_loader
    import ab_loader_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    ab_loader_if.slave    bus
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] outa_q, outa_d;
    logic [WIDTH-1:0] outb_q, outb_d;
    logic             ena_q, ena_d;
    logic             enb_q, enb_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       pair_cnt_q, pair_cnt_d;
    logic             err_q, err_d;

    logic ready;
    logic hs_a;
    logic hs_b;
    logic timeout_hit;

    assign ready       = accepts_byte(state_q);
    assign hs_a        = (state_q == WAIT_A) && bus.valid_in;
    assign hs_b        = (state_q == WAIT_B) && bus.valid_in;
    // A same-cycle ack completes the pair instead of timing out.
    assign timeout_hit = (state_q == WAIT_ACK) && !bus.ack_in && (tmo_cnt_q == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_A:   if (hs_a) state_d = WAIT_B;
            WAIT_B:   if (hs_b) state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.ack_in) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = WAIT_A;
                end
            end
            DONE:     state_d = WAIT_A;
            default:  state_d = WAIT_A;
        endcase
    end

    // Output logic decoded from state
    always_comb begin
        bus.ready_in  = ready;
        bus.pair_done = (state_q == DONE);
    end

    // Datapath next-state: operand registers, strobes, counters and error flag
    always_comb begin
        outa_d     = outa_q;
        outb_d     = outb_q;
        ena_d      = hs_a;
        enb_d      = hs_b;
        tmo_cnt_d  = tmo_cnt_q;
        pair_cnt_d = pair_cnt_q;
        err_d      = err_q;

        if (hs_a) begin
            outa_d = bus.data_in;
        end
        if (hs_b) begin
            outb_d    = bus.data_in;
            tmo_cnt_d = 8'd0;
        end else if (state_q == WAIT_ACK) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end

        if (state_q == DONE) begin
            pair_cnt_d = pair_cnt_q + 8'd1;
        end

        // Setting on timeout beats a simultaneous clear.
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outa_q     <= '0;
            outb_q     <= '0;
            ena_q      <= 1'b0;
            enb_q      <= 1'b0;
            tmo_cnt_q  <= 8'd0;
            pair_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            outa_q     <= outa_d;
            outb_q     <= outb_d;
            ena_q      <= ena_d;
            enb_q      <= enb_d;
            tmo_cnt_q  <= tmo_cnt_d;
            pair_cnt_q <= pair_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.outA       = outa_q;
    assign bus.outB       = outb_q;
    assign bus.enA        = ena_q;
    assign bus.enB        = enb_q;
    assign bus.pair_count = pair_cnt_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_ab_loader.sv
// Scoreboard bench for ab_loader: operand bytes are queued when handed over and
// matched against the enA/enB strobes; pair completion, timeout and reset are checked.
module tb_ab_loader;
    import ab_loader_pkg::*;

    localparam int W  = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ab_loader_if #(.WIDTH(W)) bus ();

    ab_loader #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    bit ack_follow = 1'b0;
    logic enb_prev = 1'b0;
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: strobes against the scoreboard, pair pulses, and the delayed-ack responder.
    always @(negedge clk) begin
        if (bus.enA || bus.enB) chk("en_overlap", {31'd0, bus.enA & bus.enB}, 32'd0);
        if (bus.enA) begin
            if (exp_a.size() == 0) chk("enA_unexpected", 32'd1, 32'd0);
            else chk("outA", {24'd0, bus.outA}, {24'd0, exp_a.pop_front()});
        end
        if (bus.enB) begin
            if (exp_b.size() == 0) chk("enB_unexpected", 32'd1, 32'd0);
            else chk("outB", {24'd0, bus.outB}, {24'd0, exp_b.pop_front()});
        end
        if (bus.pair_done) begin
            done_seen++;
            $display("pair complete: pair_count before update=%0d", bus.pair_count);
        end
        if (ack_follow) begin
            bus.ack_in = enb_prev;
            enb_prev   = bus.enB;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [W-1:0] d, input bit is_a);
        int n = 0;
        bus.data_in  = d;
        bus.valid_in = 1'b1;
        while (!bus.ready_in && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_wait", 32'd0, 32'd1);
            bus.valid_in = 1'b0;
        end else begin
            if (is_a) exp_a.push_back(d);
            else exp_b.push_back(d);
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int k;
        int n;
        bus.data_in  = 8'h3C;
        bus.valid_in = 1'b1;
        bus.ack_in   = 1'b0;
        bus.err_clr  = 1'b0;

        // Reset with valid held high
        repeat (3) @(negedge clk);
        chk("rst_outA", {24'd0, bus.outA}, 32'd0);
        chk("rst_outB", {24'd0, bus.outB}, 32'd0);
        chk("rst_enA", {31'd0, bus.enA}, 32'd0);
        chk("rst_enB", {31'd0, bus.enB}, 32'd0);
        chk("rst_done", {31'd0, bus.pair_done}, 32'd0);
        chk("rst_count", {24'd0, bus.pair_count}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", {31'd0, bus.ready_in}, 32'd1);
        exp_a.push_back(8'h3C);
        @(negedge clk);
        bus.valid_in = 1'b0;

        // Single pair, ack two cycles after enB
        send(8'hA5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.ack_in = 1'b1;
        @(negedge clk);
        bus.ack_in = 1'b0;
        chk("single_done", {31'd0, bus.pair_done}, 32'd1);
        @(negedge clk);
        #1 chk("single_done_cnt", done_seen, 32'd1);
        chk("single_count", {24'd0, bus.pair_count}, 32'd1);
        chk("single_ready", {31'd0, bus.ready_in}, 32'd1);

        // Timeout with no ack
        @(negedge clk);
        send(8'h5A, 1'b1);
        send(8'h6B, 1'b0);
        for (int i = 0; i < TO; i++) begin
            chk("tmo_err_low", {31'd0, bus.err}, 32'd0);
            @(negedge clk);
        end
        chk("tmo_err_high", {31'd0, bus.err}, 32'd1);
        chk("tmo_ready", {31'd0, bus.ready_in}, 32'd1);
        chk("tmo_count", {24'd0, bus.pair_count}, 32'd1);
        #1 chk("tmo_no_done", done_seen, 32'd1);
        send(8'h77, 1'b1);
        chk("err_sticky", {31'd0, bus.err}, 32'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_cleared", {31'd0, bus.err}, 32'd0);

        // Stray ack while in WAIT_B, then completion of the pending pair
        bus.ack_in = 1'b1;
        repeat (3) begin
            chk("stray_b_done", {31'd0, bus.pair_done}, 32'd0);
            @(negedge clk);
        end
        send(8'h99, 1'b0);
        chk("stray_ack_cyc", {31'd0, bus.pair_done}, 32'd0);
        @(negedge clk);
        chk("stray_done", {31'd0, bus.pair_done}, 32'd1);
        @(negedge clk);
        chk("stray_count", {24'd0, bus.pair_count}, 32'd2);
        repeat (2) begin
            chk("stray_a_done", {31'd0, bus.pair_done}, 32'd0);
            @(negedge clk);
        end
        bus.ack_in = 1'b0;
        #1 chk("stray_done_cnt", done_seen, 32'd2);

        // Mid-operation reset in WAIT_B
        @(negedge clk);
        send(8'h11, 1'b1);
        chk("mid_outA", {24'd0, bus.outA}, 32'h11);
        base = done_seen;
        #2 rst = 1'b1;
        #1 chk("mid_rst_outA", {24'd0, bus.outA}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.ready_in}, 32'd1);
        chk("mid_rst_count", {24'd0, bus.pair_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("mid_no_done", done_seen, base);

        // Back-to-back: valid always high, ack follows enB by one cycle
        @(negedge clk);
        base = done_seen;
        enb_prev = 1'b0;
        ack_follow = 1'b1;
        k = 0;
        n = 0;
        bus.data_in  = 8'd5;
        bus.valid_in = 1'b1;
        while (k < 512 && n < 4000) begin
            if (bus.ready_in) begin
                if (k % 2 == 0) exp_a.push_back(bus.data_in);
                else exp_b.push_back(bus.data_in);
                k++;
                @(posedge clk);
                #1 bus.data_in = 8'(k * 37 + 5);
            end
            @(negedge clk);
            n++;
        end
        bus.valid_in = 1'b0;
        chk("b2b_bytes", k, 32'd512);
        n = 0;
        while (done_seen < base + 256 && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        chk("b2b_pairs", done_seen - base, 32'd256);
        @(negedge clk);
        ack_follow = 1'b0;
        bus.ack_in = 1'b0;
        chk("b2b_wrap", {24'd0, bus.pair_count}, 32'd0);
        chk("b2b_err", {31'd0, bus.err}, 32'd0);
        chk("queues_empty", exp_a.size() + exp_b.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
